kernel_ddr3_mem_dmaster_p2b_encoder: RTL and testbench

- Packets-to-bytes encoder on the DDR3 debug-master return path.
- Takes the Avalon-ST packet stream (data, channel, SOP/EOP) and serialises it into a plain byte stream for the byte transport.
- Framing and escape codes are inserted in-band.
- It is the transmit-side counterpart of the bytes-to-packets decode/channel-adapter stage.

---
 rtl/kernel_ddr3_mem_dmaster_p2b_encoder.sv | 137 +++++++++++++
 tb/tb_kernel_ddr3_mem_dmaster_p2b_encoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/kernel_ddr3_mem_dmaster_p2b_encoder.sv
// Packets-to-bytes encoder: serialises an Avalon-ST packet stream into a byte stream with in-band
// SOP/EOP/channel markers and escapes. Define P2B_CHANNEL_EN to emit channel markers.
module kernel_ddr3_mem_dmaster_p2b_encoder #(
  parameter int         CHANNEL_WIDTH = 8,
  parameter logic [7:0] SOP_CHAR      = 8'h7A,
  parameter logic [7:0] EOP_CHAR      = 8'h7B,
  parameter logic [7:0] CH_CHAR       = 8'h7C,
  parameter logic [7:0] ESC_CHAR      = 8'h7D
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  // Encoding order matters: states after IDLE follow the emission order of a beat.
  typedef enum logic [2:0] {
    IDLE, CH_MARK, CH_ESC, CH_VAL, SOP_MARK, EOP_MARK, D_ESC, D_VAL
  } state_t;

  state_t     state_q, state_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       ld, go, need_ch, ch_spec, d_spec, ch_upd, found;
  logic [7:0] ch8, byte_sel, req;
  logic [2:0] cur, nxt;

  function automatic logic special(input logic [7:0] b);
    return (b >= 8'h7A) && (b <= 8'h7D);
  endfunction

`ifdef P2B_CHANNEL_EN
  logic       ch_known_q, ch_known_d;
  logic [7:0] last_ch_q, last_ch_d;

  always_comb begin
    ch8 = '0;
    ch8[CHANNEL_WIDTH-1:0] = in_channel;
  end
  assign need_ch = in_startofpacket || !ch_known_q || (ch8 != last_ch_q);

  always_comb begin
    ch_known_d = ch_known_q || ch_upd;
    last_ch_d  = ch_upd ? ch8 : last_ch_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_known_q <= 1'b0;
      last_ch_q  <= 8'h00;
    end else begin
      ch_known_q <= ch_known_d;
      last_ch_q  <= last_ch_d;
    end
  end
`else
  logic unused_ok;
  assign ch8       = 8'h00;
  assign need_ch   = 1'b0;
  assign unused_ok = ^{in_channel, ch_upd};
`endif

  always_comb begin
    ld      = !out_valid_q || out_ready;
    ch_spec = special(ch8);
    d_spec  = special(in_data);
    // Bit i set when the element encoded by state value i is part of this beat.
    req = {1'b1, d_spec, in_endofpacket, in_startofpacket,
           need_ch, need_ch && ch_spec, need_ch, 1'b0};

    found = 1'b0;
    cur   = 3'd7;
    if (state_q == IDLE) begin
      for (int i = 1; i < 8; i++)
        if (!found && req[i]) begin
          cur   = 3'(i);
          found = 1'b1;
        end
    end else begin
      cur = state_q;
    end

    found = 1'b0;
    nxt   = 3'd0;
    for (int i = 1; i < 8; i++)
      if (!found && (3'(i) > cur) && req[i]) begin
        nxt   = 3'(i);
        found = 1'b1;
      end

    case (state_t'(cur))
      CH_MARK:       byte_sel = CH_CHAR;
      CH_ESC, D_ESC: byte_sel = ESC_CHAR;
      CH_VAL:        byte_sel = ch_spec ? (ch8 ^ 8'h20) : ch8;
      SOP_MARK:      byte_sel = SOP_CHAR;
      EOP_MARK:      byte_sel = EOP_CHAR;
      default:       byte_sel = d_spec ? (in_data ^ 8'h20) : in_data;
    endcase

    go          = (state_q == IDLE) ? (in_valid && ld) : ld;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ch_upd      = go && (cur == 3'(CH_VAL));
    if (go) begin
      out_valid_d = 1'b1;
      out_data_d  = byte_sel;
      state_d     = state_t'(nxt);
    end else if (ld) begin
      out_valid_d = 1'b0;
    end
    in_ready = go && (nxt == 3'd0) && !reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_kernel_ddr3_mem_dmaster_p2b_encoder.sv
// Bench for the packets-to-bytes encoder: directed vector table, hand-written backpressure and
// reset sequences, then random beats scored against a byte-list model of the encoding rules.
module tb_kernel_ddr3_mem_dmaster_p2b_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_ready, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00, in_channel = 8'h00;
  logic       in_startofpacket = 1'b0, in_endofpacket = 1'b0;
  logic       out_ready = 1'b1, out_valid;
  logic [7:0] out_data;

  kernel_ddr3_mem_dmaster_p2b_encoder #(.CHANNEL_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_channel(in_channel), .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data));

  always #5 clk = ~clk;

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] expq[$];
  bit         m_known = 1'b0;
  logic [7:0] m_last = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: list of bytes a beat must produce, straight from the framing rules.
  task automatic model_beat(input logic [7:0] ch, input logic [7:0] d, input logic sop,
                            input logic eop, input bit push, output int n);
    logic [7:0] b[$];
`ifdef P2B_CHANNEL_EN
    if (sop || !m_known || ch != m_last) begin
      b.push_back(8'h7C);
      if (ch inside {[8'h7A:8'h7D]}) begin b.push_back(8'h7D); b.push_back(ch ^ 8'h20); end
      else b.push_back(ch);
      m_known = 1'b1;
      m_last  = ch;
    end
`endif
    if (sop) b.push_back(8'h7A);
    if (eop) b.push_back(8'h7B);
    if (d inside {[8'h7A:8'h7D]}) begin b.push_back(8'h7D); b.push_back(d ^ 8'h20); end
    else b.push_back(d);
    n = b.size();
    if (push) foreach (b[i]) expq.push_back(b[i]);
  endtask

  // Output scoreboard plus stall-stability check.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(posedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("unexpected_byte", 32'(out_data), 32'hFFFF);
        else chk("out_byte", 32'(out_data), 32'(expq.pop_front()));
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  // Called at a negedge; returns at the negedge after the beat was consumed.
  task automatic send_beat(input logic [7:0] ch, input logic [7:0] d, input logic sop,
                           input logic eop, input bit rnd, output int waits);
    bit ok = 1'b0;
    in_channel = ch; in_data = d; in_startofpacket = sop; in_endofpacket = eop; in_valid = 1'b1;
    waits = 0;
    for (int n = 0; n < 200; n++) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (in_ready) begin ok = 1'b1; @(negedge clk); break; end
      waits++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0]      ch, d;
    logic            sop, eop;
    int              n;
    logic [0:6][7:0] e;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int waits, nm;
    logic [7:0] rch, rd;
`ifdef P2B_CHANNEL_EN
    vecs[0] = '{8'h02, 8'h11, 1'b1, 1'b0, 4, 56'h7C_02_7A_11_00_00_00};
    vecs[1] = '{8'h02, 8'h22, 1'b0, 1'b0, 1, 56'h22_00_00_00_00_00_00};
    vecs[2] = '{8'h02, 8'h33, 1'b0, 1'b1, 2, 56'h7B_33_00_00_00_00_00};
    vecs[3] = '{8'h7B, 8'h7D, 1'b1, 1'b1, 7, 56'h7C_7D_5B_7A_7B_7D_5D};
    vecs[4] = '{8'h01, 8'h40, 1'b0, 1'b0, 3, 56'h7C_01_40_00_00_00_00};
    vecs[5] = '{8'h01, 8'h44, 1'b0, 1'b0, 1, 56'h44_00_00_00_00_00_00};
    vecs[6] = '{8'h03, 8'h55, 1'b0, 1'b0, 3, 56'h7C_03_55_00_00_00_00};
`else
    vecs[0] = '{8'h02, 8'h11, 1'b1, 1'b0, 2, 56'h7A_11_00_00_00_00_00};
    vecs[1] = '{8'h02, 8'h22, 1'b0, 1'b0, 1, 56'h22_00_00_00_00_00_00};
    vecs[2] = '{8'h02, 8'h33, 1'b0, 1'b1, 2, 56'h7B_33_00_00_00_00_00};
    vecs[3] = '{8'h7B, 8'h7D, 1'b1, 1'b1, 4, 56'h7A_7B_7D_5D_00_00_00};
    vecs[4] = '{8'h01, 8'h40, 1'b0, 1'b0, 1, 56'h40_00_00_00_00_00_00};
    vecs[5] = '{8'h01, 8'h44, 1'b0, 1'b0, 1, 56'h44_00_00_00_00_00_00};
    vecs[6] = '{8'h03, 8'h55, 1'b0, 1'b0, 1, 56'h55_00_00_00_00_00_00};
`endif
    vecs[7] = '{8'h03, 8'h7C, 1'b0, 1'b0, 2, 56'h7D_5C_00_00_00_00_00};

    // Reset state; a single-byte beat offered during reset must not be consumed.
    in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      model_beat(vecs[i].ch, vecs[i].d, vecs[i].sop, vecs[i].eop, 1'b0, nm);
      for (int k = 0; k < vecs[i].n; k++) expq.push_back(vecs[i].e[k]);
      send_beat(vecs[i].ch, vecs[i].d, vecs[i].sop, vecs[i].eop, 1'b0, waits);
      chk("in_ready_timing", 32'(waits), 32'(vecs[i].n - 1));
    end

    // Backpressure across the escape pair of data 7A on the current channel.
    expq.push_back(8'h7D); expq.push_back(8'h5A);
    in_channel = 8'h03; in_data = 8'h7A; in_startofpacket = 0; in_endofpacket = 0;
    in_valid = 1'b1; out_ready = 1'b1; #1;
    chk("bp_ready0", 32'(in_ready), 32'd0);
    @(negedge clk); out_ready = 1'b0; #1;
    chk("bp_esc_a", 32'(out_data), 32'h7D);
    chk("bp_ready1", 32'(in_ready), 32'd0);
    @(negedge clk); out_ready = 1'b0; #1;
    chk("bp_esc_b", 32'(out_data), 32'h7D);
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_ready2", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("bp_val", 32'(out_data), 32'h5A);

    // Reset while the data escape pair is in flight.
`ifdef P2B_CHANNEL_EN
    expq.push_back(8'h7C); expq.push_back(8'h02);
`endif
    expq.push_back(8'h7A);
    in_channel = 8'h02; in_data = 8'h7D; in_startofpacket = 1'b1; in_endofpacket = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    begin
      bit seen = 1'b0;
      @(negedge clk); #1;
      for (int n = 0; n < 10; n++) begin
        if (out_valid && out_data == 8'h7D) begin seen = 1'b1; break; end
        @(negedge clk); #1;
      end
      chk("esc_seen", 32'(seen), 32'd1);
    end
    reset = 1'b1; #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    in_valid = 1'b0; in_startofpacket = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    m_known = 1'b0; m_last = 8'h00;
    model_beat(8'h02, 8'h21, 1'b0, 1'b0, 1'b1, nm);
    send_beat(8'h02, 8'h21, 1'b0, 1'b0, 1'b0, waits);
    chk("post_rst_timing", 32'(waits), 32'(nm - 1));

    // Randomized beats with random backpressure.
    rch = 8'h02;
    for (int b = 0; b < 400; b++) begin
      logic s, e;
      if ($urandom_range(0, 3) == 0)
        rch = $urandom_range(0, 1) ? 8'h7A + 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 3));
      rd = $urandom_range(0, 1) ? 8'h78 + 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 3) == 0);
      model_beat(rch, rd, s, e, 1'b1, nm);
      send_beat(rch, rd, s, e, 1'b1, waits);
    end

    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("exp_empty", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
